memgen_rr_arbiter: RTL
======================

MEMGEN_RR_ARBITER -- requirements
Module: memgen_rr_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, memory address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Parameter INIT_VAL, default 0, DATA_W-bit word written to every location during initialization.
REQ-004 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Ports req0_valid/req1_valid  input  1  requester n has a pending access.
REQ-007 Ports req0_ready/req1_ready  output  1  access granted this cycle.
REQ-008 Ports req0_we/req1_we  input  1  1 = write, 0 = read.
REQ-009 Ports req0_addr/req1_addr  input  ADDR_W  access address.
REQ-010 Ports req0_wdata/req1_wdata  input  DATA_W  write data.
REQ-011 Ports rsp0_valid/rsp1_valid  output  1  read data valid for requester n.
REQ-012 Ports rsp0_rdata/rsp1_rdata  output  DATA_W  read data.
REQ-013 Ports mem_chip_en, mem_wr_en, mem_rd_en  output  1  memory macro controls.
REQ-014 Port mem_addr  output  ADDR_W; port mem_wr_data  output  DATA_W; port mem_rd_data  input  DATA_W (valid one cycle after mem_rd_en).
REQ-015 Port init_done  output  1  initialization complete, requests accepted.

Function
REQ-016 FSM states ST_INIT and ST_RUN; reset enters ST_INIT with init address 0.
REQ-017 ST_INIT: each cycle drive chip_en=1, wr_en=1, rd_en=0, mem_addr=init address, mem_wr_data=INIT_VAL; increment address.
REQ-018 After writing address 2^ADDR_W-1, move to ST_RUN; init_done=1 from the next cycle onward; no address wrap-around occurs in ST_INIT.
REQ-019 In ST_INIT both req_ready SHALL be 0.
REQ-020 ST_RUN: grant is combinational; at most one reqN_ready per cycle, only when reqN_valid=1.
REQ-021 Only one requester valid -> that requester is granted.
REQ-022 Both valid -> grant the requester not granted most recently; the pointer updates only on a grant and favours req0 after reset.
REQ-023 On a grant, drive chip_en=1, wr_en=we, rd_en=~we, mem_addr and mem_wr_data from the granted requester in the same cycle; no grant -> all three enables 0.
REQ-024 Requesters hold addr/we/wdata stable while valid and not ready; the arbiter never drops a valid request.
REQ-025 A read grant in cycle T produces rspN_valid=1 for exactly cycle T+1 with rspN_rdata=mem_rd_data; writes produce no response.
REQ-026 Read latency is exactly 1 cycle; throughput is one access per cycle sustained.
REQ-027 rspN_rdata holds its last value when rspN_valid=0.

Reset
REQ-028 While reset=1, all outputs are 0: req_ready, rsp_valid, rsp_rdata, mem enables, mem_addr, mem_wr_data, init_done.
REQ-029 Reset asserted mid-INIT or mid-RUN discards any in-flight read response and restarts INIT at address 0.

Configuration
REQ-030 Macro MEMGEN_ARB_STATS_EN defined: add outputs grant_cnt0/grant_cnt1 (16 bits each), counting grants per requester, saturating at 0xFFFF, cleared by reset.
REQ-031 Macro undefined: the ports and counters are absent; all other behaviour is identical.

Structure
REQ-032 Package memgen_arb_pkg holds the state enum (ST_INIT, ST_RUN) and the default ADDR_W/DATA_W constants.
REQ-033 Sub-module memgen_rr_pick implements the 2-way round-robin selection and pointer.

Verification
REQ-034 Release reset -> 1024 cycles of wr_en=1, addr 0..1023, wr_data 0x0000, ready=0; init_done=1 on the cycle after addr 1023.
REQ-035 After init, req0 reads 0x005 and req1 reads 0x006 in the same cycle T -> req0 granted T, req1 granted T+1; rsp0_valid at T+1, rsp1_valid at T+2, both rdata 0x0000.
REQ-036 req0 writes 0xBEEF to 0x3FF, then req1 reads 0x3FF -> rsp1_rdata=0xBEEF, rsp0_valid stays 0.
REQ-037 Both valid continuously for 6 cycles -> grant order 0,1,0,1,0,1; with MEMGEN_ARB_STATS_EN, grant_cnt0=3 and grant_cnt1=3.
REQ-038 Assert reset at init address 500 -> outputs 0 during reset; INIT restarts at 0 and completes after 1024 further cycles.
REQ-039 With MEMGEN_ARB_STATS_EN, 65540 grants to req0 -> grant_cnt0 holds at 0xFFFF.

Source files
------------

// File: rtl/memgen_arb_pkg.sv
// -----------------------------------------------------------------------------
// memgen_arb_pkg
// Shared definitions for the memory-initialising round-robin arbiter:
//   - default address / data widths
//   - controller state encoding (ST_INIT sweeps the memory, ST_RUN arbitrates)
// -----------------------------------------------------------------------------
package memgen_arb_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;

  // Width of the optional per-requester grant counters.
  localparam int STAT_W = 16;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/memgen_rr_pick.sv
// -----------------------------------------------------------------------------
// memgen_rr_pick
// Two-way round-robin selector. The grant is purely combinational from the
// current valids and the "last winner" pointer; the pointer only moves when a
// grant is actually issued. After reset the pointer says requester 1 won last,
// so requester 0 is preferred on the first contended cycle.
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   en_i      in   arbitration enabled (0 forces both grants low)
//   valid0_i  in   requester 0 has a pending access
//   valid1_i  in   requester 1 has a pending access
//   grant0_o  out  requester 0 granted this cycle
//   grant1_o  out  requester 1 granted this cycle
// -----------------------------------------------------------------------------
module memgen_rr_pick (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  input  logic valid0_i,
  input  logic valid1_i,
  output logic grant0_o,
  output logic grant1_o
);

  // 1 = requester 1 received the most recent grant.
  logic last1_q;
  logic last1_d;

  // Grant selection and pointer next-state.
  always_comb begin
    grant0_o = 1'b0;
    grant1_o = 1'b0;
    last1_d  = last1_q;
    if (en_i) begin
      if (valid0_i && valid1_i) begin
        // Contention: serve whoever did not win last time.
        grant0_o = last1_q;
        grant1_o = ~last1_q;
      end else begin
        grant0_o = valid0_i;
        grant1_o = valid1_i;
      end
      if (grant0_o) begin
        last1_d = 1'b0;
      end else if (grant1_o) begin
        last1_d = 1'b1;
      end else begin
        last1_d = last1_q;
      end
    end else begin
      grant0_o = 1'b0;
      grant1_o = 1'b0;
      last1_d  = last1_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clock) begin
    if (reset) begin
      last1_q <= 1'b1;
    end else begin
      last1_q <= last1_d;
    end
  end

endmodule

// File: rtl/memgen_rr_arbiter.sv
// -----------------------------------------------------------------------------
// memgen_rr_arbiter
// Front end for a single-port memory macro shared by two requesters.
// After reset the whole memory is written with INIT_VAL (one word per cycle,
// address 0 upward). Once the last address is written, init_done rises and
// the two requesters are arbitrated round-robin, one access per cycle.
// A read granted in cycle T returns mem_rd_data on rspN_rdata in cycle T+1
// with rspN_valid high for that single cycle; rspN_rdata then holds it.
//
// Optional feature (macro MEMGEN_ARB_STATS_EN): adds grant_cnt0/grant_cnt1,
// saturating 16-bit per-requester grant counters cleared by reset.
//
// Ports
//   clock, reset                 clock and synchronous active-high reset
//   reqN_valid/_we/_addr/_wdata  requester N access (held while not ready)
//   reqN_ready                   requester N granted this cycle
//   rspN_valid/_rdata            read response for requester N
//   mem_chip_en/_wr_en/_rd_en    memory macro controls
//   mem_addr/_wr_data            memory address and write data
//   mem_rd_data                  memory read data (one cycle after rd_en)
//   init_done                    initialization finished, requests accepted
//   grant_cnt0/1                 grant counters (MEMGEN_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module memgen_rr_arbiter
  import memgen_arb_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_chip_en,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              init_done
`ifdef MEMGEN_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
  logic              run_s;
  logic              grant0_s, grant1_s;
  logic              rsp0_pend_q, rsp0_pend_d;
  logic              rsp1_pend_q, rsp1_pend_d;
  logic [DATA_W-1:0] rsp0_hold_q, rsp0_hold_d;
  logic [DATA_W-1:0] rsp1_hold_q, rsp1_hold_d;

  // Reset overrides everything combinational, so outputs are 0 while it is high.
  assign run_s = (state_q == ST_RUN) && !reset;

  // Init sweep / run state next-state logic.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      ST_INIT: begin
        // The last address hands over to RUN instead of wrapping.
        if (init_addr_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end else begin
          init_addr_d = init_addr_q + ADDR_ONE;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d     = ST_INIT;
        init_addr_d = ADDR_ZERO;
      end
    endcase
  end

  // State and init address registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= ADDR_ZERO;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  memgen_rr_pick u_pick (
    .clock    (clock),
    .reset    (reset),
    .en_i     (run_s),
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .grant0_o (grant0_s),
    .grant1_o (grant1_s)
  );

  // Memory macro drive: init sweep, granted access, or idle.
  always_comb begin
    mem_chip_en = 1'b0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = ADDR_ZERO;
    mem_wr_data = DATA_ZERO;
    if (reset) begin
      mem_chip_en = 1'b0;
    end else if (state_q == ST_INIT) begin
      mem_chip_en = 1'b1;
      mem_wr_en   = 1'b1;
      mem_addr    = init_addr_q;
      mem_wr_data = INIT_VAL;
    end else if (grant0_s) begin
      mem_chip_en = 1'b1;
      mem_wr_en   = req0_we;
      mem_rd_en   = ~req0_we;
      mem_addr    = req0_addr;
      mem_wr_data = req0_wdata;
    end else if (grant1_s) begin
      mem_chip_en = 1'b1;
      mem_wr_en   = req1_we;
      mem_rd_en   = ~req1_we;
      mem_addr    = req1_addr;
      mem_wr_data = req1_wdata;
    end else begin
      mem_chip_en = 1'b0;
    end
  end

  // Response tracking: a read grant marks the next cycle as the data cycle;
  // the data seen in that cycle is captured so rdata can hold it afterwards.
  always_comb begin
    rsp0_pend_d = grant0_s & ~req0_we;
    rsp1_pend_d = grant1_s & ~req1_we;
    rsp0_hold_d = rsp0_hold_q;
    rsp1_hold_d = rsp1_hold_q;
    if (rsp0_pend_q) begin
      rsp0_hold_d = mem_rd_data;
    end else begin
      rsp0_hold_d = rsp0_hold_q;
    end
    if (rsp1_pend_q) begin
      rsp1_hold_d = mem_rd_data;
    end else begin
      rsp1_hold_d = rsp1_hold_q;
    end
  end

  // Response registers; reset discards any read still in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp0_pend_q <= 1'b0;
      rsp1_pend_q <= 1'b0;
      rsp0_hold_q <= DATA_ZERO;
      rsp1_hold_q <= DATA_ZERO;
    end else begin
      rsp0_pend_q <= rsp0_pend_d;
      rsp1_pend_q <= rsp1_pend_d;
      rsp0_hold_q <= rsp0_hold_d;
      rsp1_hold_q <= rsp1_hold_d;
    end
  end

  // Handshake and response outputs. Read data passes straight through in the
  // data cycle because the macro only presents it one cycle after rd_en.
  always_comb begin
    req0_ready = grant0_s;
    req1_ready = grant1_s;
    init_done  = run_s;
    rsp0_valid = rsp0_pend_q & ~reset;
    rsp1_valid = rsp1_pend_q & ~reset;
    rsp0_rdata = DATA_ZERO;
    rsp1_rdata = DATA_ZERO;
    if (reset) begin
      rsp0_rdata = DATA_ZERO;
      rsp1_rdata = DATA_ZERO;
    end else begin
      rsp0_rdata = rsp0_pend_q ? mem_rd_data : rsp0_hold_q;
      rsp1_rdata = rsp1_pend_q ? mem_rd_data : rsp1_hold_q;
    end
  end

`ifdef MEMGEN_ARB_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  logic [STAT_W-1:0] cnt0_q, cnt0_d;
  logic [STAT_W-1:0] cnt1_q, cnt1_d;

  // Saturating grant counters.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (grant0_s && (cnt0_q != STAT_MAX)) begin
      cnt0_d = cnt0_q + STAT_ONE;
    end else begin
      cnt0_d = cnt0_q;
    end
    if (grant1_s && (cnt1_q != STAT_MAX)) begin
      cnt1_d = cnt1_q + STAT_ONE;
    end else begin
      cnt1_d = cnt1_q;
    end
  end

  // Grant counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt0_q <= {STAT_W{1'b0}};
      cnt1_q <= {STAT_W{1'b0}};
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = reset ? {STAT_W{1'b0}} : cnt0_q;
  assign grant_cnt1 = reset ? {STAT_W{1'b0}} : cnt1_q;
`else
  // Statistics disabled: grants are not counted and no counter ports exist.
`endif

endmodule
